// File: rtl/regfile_arbiter.sv
// Round-robin two-requester arbiter/sequencer in front of a 32x32 register file, with RMW lock.
// Latency: grant and register-file drive are combinational; read data is registered, valid 1 cycle after accept.
// Backpressure: ready only for the granted valid requester; responses have no backpressure.
module regfile_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_we_i,
  input  logic [ADDR_W-1:0] req0_ra_i,
  input  logic [ADDR_W-1:0] req0_rb_i,
  input  logic [ADDR_W-1:0] req0_rw_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  input  logic              req0_lock_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_we_i,
  input  logic [ADDR_W-1:0] req1_ra_i,
  input  logic [ADDR_W-1:0] req1_rb_i,
  input  logic [ADDR_W-1:0] req1_rw_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  input  logic              req1_lock_i,
  output logic              rsp0_valid_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp_a_o,
  output logic [DATA_W-1:0] rsp_b_o,
  output logic [ADDR_W-1:0] aa_o,
  output logic [ADDR_W-1:0] ab_o,
  output logic [ADDR_W-1:0] aw_o,
  output logic              wren_o,
  output logic [DATA_W-1:0] wrdata_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i
);

  logic              gnt0, gnt1, any_gnt, sel;
  logic              sel_we, sel_lock, rd_acc;
  logic [ADDR_W-1:0] sel_ra, sel_rb, sel_rw;
  logic [DATA_W-1:0] sel_wdata;

  logic              last_q, last_d;
  logic              lock_q, lock_d;
  logic              owner_q, owner_d;
  logic              rsp0_vld_q, rsp0_vld_d;
  logic              rsp1_vld_q, rsp1_vld_d;
  logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
  logic [DATA_W-1:0] rsp_b_q, rsp_b_d;

  // Grant: a lock pins the grant to its owner; otherwise a lone requester wins, and on contention the one not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_q) begin
      gnt0 = req0_valid_i && !owner_q;
      gnt1 = req1_valid_i &&  owner_q;
    end else if (req0_valid_i && req1_valid_i) begin
      gnt0 = last_q;
      gnt1 = !last_q;
    end else begin
      gnt0 = req0_valid_i;
      gnt1 = req1_valid_i;
    end
  end

  // Mux the granted requester's transaction fields.
  always_comb begin
    sel       = gnt1;
    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? req1_we_i    : req0_we_i;
    sel_lock  = gnt1 ? req1_lock_i  : req0_lock_i;
    sel_ra    = gnt1 ? req1_ra_i    : req0_ra_i;
    sel_rb    = gnt1 ? req1_rb_i    : req0_rb_i;
    sel_rw    = gnt1 ? req1_rw_i    : req0_rw_i;
    sel_wdata = gnt1 ? req1_wdata_i : req0_wdata_i;
    rd_acc    = any_gnt && !sel_we;
  end

  // Register-file drive: idle outputs are zero; writes to x0 are accepted but never strobe wren; no write while in reset.
  always_comb begin
    aa_o     = '0;
    ab_o     = '0;
    aw_o     = '0;
    wren_o   = 1'b0;
    wrdata_o = '0;
    if (any_gnt) begin
      if (sel_we) begin
        aw_o     = sel_rw;
        wrdata_o = sel_wdata;
        wren_o   = (sel_rw != '0) && !rst_i;
      end else begin
        aa_o = sel_ra;
        ab_o = sel_rb;
      end
    end
  end

  // Next state: round-robin pointer, lock ownership and the one-cycle read response.
  always_comb begin
    last_d     = last_q;
    lock_d     = lock_q;
    owner_d    = owner_q;
    rsp_a_d    = rsp_a_q;
    rsp_b_d    = rsp_b_q;
    rsp0_vld_d = rd_acc && !sel;
    rsp1_vld_d = rd_acc &&  sel;
    if (any_gnt) begin
      last_d = sel;
      lock_d = sel_lock;
      if (sel_lock) owner_d = sel;
    end
    if (rd_acc) begin
      rsp_a_d = a_i;
      rsp_b_d = b_i;
    end
  end

  // State registers; last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
      rsp_a_q    <= '0;
      rsp_b_q    <= '0;
    end else begin
      last_q     <= last_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      rsp0_vld_q <= rsp0_vld_d;
      rsp1_vld_q <= rsp1_vld_d;
      rsp_a_q    <= rsp_a_d;
      rsp_b_q    <= rsp_b_d;
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign rsp0_valid_o = rsp0_vld_q;
  assign rsp1_valid_o = rsp1_vld_q;
  assign rsp_a_o      = rsp_a_q;
  assign rsp_b_o      = rsp_b_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file attached.
// Inputs change on the falling edge; outputs are checked 1ns later, away from the rising edge.
// Each table row is one cycle: the row's requests plus the expected outputs in that same cycle.
module tb_regfile_arbiter;

  localparam logic [31:0] B = 32'h1000_0000;

  typedef struct packed {
    logic        v;
    logic        we;
    logic        lk;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    req_t        r0;
    req_t        r1;
    logic        rdy0;
    logic        rdy1;
    logic        wren;
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic [4:0]  aw;
    logic [31:0] wd;
    logic        r0v;
    logic        r1v;
    logic [31:0] ra;
    logic [31:0] rb;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req0_valid_i, req0_we_i, req0_lock_i, req0_ready_o;
  logic        req1_valid_i, req1_we_i, req1_lock_i, req1_ready_o;
  logic [4:0]  req0_ra_i, req0_rb_i, req0_rw_i, req1_ra_i, req1_rb_i, req1_rw_i;
  logic [31:0] req0_wdata_i, req1_wdata_i;
  logic        rsp0_valid_o, rsp1_valid_o, wren_o;
  logic [31:0] rsp_a_o, rsp_b_o, wrdata_o, a_i, b_i;
  logic [4:0]  aa_o, ab_o, aw_o;

  int n_checks = 0;
  int n_errors = 0;

  regfile_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_ra_i(req0_ra_i), .req0_rb_i(req0_rb_i), .req0_rw_i(req0_rw_i),
    .req0_wdata_i(req0_wdata_i), .req0_lock_i(req0_lock_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_ra_i(req1_ra_i), .req1_rb_i(req1_rb_i), .req1_rw_i(req1_rw_i),
    .req1_wdata_i(req1_wdata_i), .req1_lock_i(req1_lock_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
    .rsp_a_o(rsp_a_o), .rsp_b_o(rsp_b_o),
    .aa_o(aa_o), .ab_o(ab_o), .aw_o(aw_o), .wren_o(wren_o), .wrdata_o(wrdata_o),
    .a_i(a_i), .b_i(b_i)
  );

  always #5 clk_i = ~clk_i;

  // Register file: unwritten registers read as B + index, x0 always reads zero.
  logic [31:0] seen = '0;
  logic [31:0] rf [32];

  always @(posedge clk_i) begin
    if (wren_o && aw_o != 5'd0) begin
      rf[aw_o]   <= wrdata_o;
      seen[aw_o] <= 1'b1;
    end
  end

  assign a_i = (aa_o == 5'd0) ? 32'd0 : (seen[aa_o] ? rf[aa_o] : B + {27'd0, aa_o});
  assign b_i = (ab_o == 5'd0) ? 32'd0 : (seen[ab_o] ? rf[ab_o] : B + {27'd0, ab_o});

  function automatic req_t idle();
    req_t r;
    r = '0;
    return r;
  endfunction

  function automatic req_t rd(logic [4:0] ra, logic [4:0] rb, logic lk);
    req_t r;
    r    = '0;
    r.v  = 1'b1;
    r.ra = ra;
    r.rb = rb;
    r.lk = lk;
    return r;
  endfunction

  function automatic req_t wr(logic [4:0] rw, logic [31:0] wd, logic lk);
    req_t r;
    r    = '0;
    r.v  = 1'b1;
    r.we = 1'b1;
    r.rw = rw;
    r.wd = wd;
    r.lk = lk;
    return r;
  endfunction

  task automatic apply(input req_t a, input req_t b);
    req0_valid_i = a.v;  req0_we_i = a.we; req0_lock_i = a.lk;
    req0_ra_i = a.ra;    req0_rb_i = a.rb; req0_rw_i = a.rw; req0_wdata_i = a.wd;
    req1_valid_i = b.v;  req1_we_i = b.we; req1_lock_i = b.lk;
    req1_ra_i = b.ra;    req1_rb_i = b.rb; req1_rw_i = b.rw; req1_wdata_i = b.wd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  vec_t vecs [15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Row fields: r0, r1, rdy0, rdy1, wren, aa, ab, aw, wdata, rsp0_valid, rsp1_valid, rsp_a, rsp_b.
    vecs[0]  = '{rd(5'd0, 5'd2, 1'b0), idle(), 1'b1, 1'b0, 1'b0, 5'd0, 5'd2, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[1]  = '{wr(5'd2, 32'h0000_00FF, 1'b0), idle(), 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd2, 32'h0000_00FF, 1'b1, 1'b0, 32'd0, B + 32'd2};
    vecs[2]  = '{rd(5'd2, 5'd5, 1'b0), idle(), 1'b1, 1'b0, 1'b0, 5'd2, 5'd5, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, B + 32'd2};
    vecs[3]  = '{rd(5'd1, 5'd3, 1'b0), rd(5'd4, 5'd6, 1'b0), 1'b0, 1'b1, 1'b0, 5'd4, 5'd6, 5'd0, 32'd0, 1'b1, 1'b0, 32'h0000_00FF, B + 32'd5};
    vecs[4]  = '{rd(5'd1, 5'd3, 1'b0), rd(5'd4, 5'd6, 1'b0), 1'b1, 1'b0, 1'b0, 5'd1, 5'd3, 5'd0, 32'd0, 1'b0, 1'b1, B + 32'd4, B + 32'd6};
    vecs[5]  = '{rd(5'd1, 5'd3, 1'b0), rd(5'd4, 5'd6, 1'b0), 1'b0, 1'b1, 1'b0, 5'd4, 5'd6, 5'd0, 32'd0, 1'b1, 1'b0, B + 32'd1, B + 32'd3};
    vecs[6]  = '{idle(), wr(5'd0, 32'hFFFF_FFFF, 1'b0), 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, B + 32'd4, B + 32'd6};
    vecs[7]  = '{idle(), rd(5'd0, 5'd0, 1'b0), 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, B + 32'd4, B + 32'd6};
    vecs[8]  = '{rd(5'd7, 5'd8, 1'b0), idle(), 1'b1, 1'b0, 1'b0, 5'd7, 5'd8, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0};
    vecs[9]  = '{rd(5'd7, 5'd8, 1'b0), rd(5'd5, 5'd5, 1'b1), 1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'd0, 1'b1, 1'b0, B + 32'd7, B + 32'd8};
    vecs[10] = '{rd(5'd7, 5'd8, 1'b0), wr(5'd5, 32'h1234_5678, 1'b0), 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'h1234_5678, 1'b0, 1'b1, B + 32'd5, B + 32'd5};
    vecs[11] = '{rd(5'd7, 5'd8, 1'b0), rd(5'd5, 5'd5, 1'b0), 1'b1, 1'b0, 1'b0, 5'd7, 5'd8, 5'd0, 32'd0, 1'b0, 1'b0, B + 32'd5, B + 32'd5};
    vecs[12] = '{idle(), rd(5'd5, 5'd5, 1'b0), 1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'd0, 1'b1, 1'b0, B + 32'd7, B + 32'd8};
    vecs[13] = '{idle(), idle(), 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[14] = '{idle(), idle(), 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678};

    // Reset state, with no requests.
    apply(idle(), idle());
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_rsp0_valid", {31'd0, rsp0_valid_o}, 32'd0);
    chk("reset_rsp1_valid", {31'd0, rsp1_valid_o}, 32'd0);
    chk("reset_rsp_a", rsp_a_o, 32'd0);
    chk("reset_ready0", {31'd0, req0_ready_o}, 32'd0);

    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].r0, vecs[i].r1);
      #1;
      chk($sformatf("v%0d_ready0", i), {31'd0, req0_ready_o}, {31'd0, vecs[i].rdy0});
      chk($sformatf("v%0d_ready1", i), {31'd0, req1_ready_o}, {31'd0, vecs[i].rdy1});
      chk($sformatf("v%0d_wren", i), {31'd0, wren_o}, {31'd0, vecs[i].wren});
      chk($sformatf("v%0d_aa", i), {27'd0, aa_o}, {27'd0, vecs[i].aa});
      chk($sformatf("v%0d_ab", i), {27'd0, ab_o}, {27'd0, vecs[i].ab});
      chk($sformatf("v%0d_aw", i), {27'd0, aw_o}, {27'd0, vecs[i].aw});
      chk($sformatf("v%0d_wrdata", i), wrdata_o, vecs[i].wd);
      chk($sformatf("v%0d_rsp0_valid", i), {31'd0, rsp0_valid_o}, {31'd0, vecs[i].r0v});
      chk($sformatf("v%0d_rsp1_valid", i), {31'd0, rsp1_valid_o}, {31'd0, vecs[i].r1v});
      chk($sformatf("v%0d_rsp_a", i), rsp_a_o, vecs[i].ra);
      chk($sformatf("v%0d_rsp_b", i), rsp_b_o, vecs[i].rb);
      @(negedge clk_i);
    end

    // Requester 1 takes a lock with a read of x9/x10.
    apply(idle(), rd(5'd9, 5'd10, 1'b1));
    #1;
    chk("lk_take_ready1", {31'd0, req1_ready_o}, 32'd1);
    @(negedge clk_i);
    // Owner idle while locked: requester 0 must not be granted; the read response is showing.
    apply(rd(5'd1, 5'd1, 1'b0), idle());
    #1;
    chk("lk_idle_ready0", {31'd0, req0_ready_o}, 32'd0);
    chk("lk_idle_ready1", {31'd0, req1_ready_o}, 32'd0);
    chk("lk_idle_rsp1_valid", {31'd0, rsp1_valid_o}, 32'd1);
    chk("lk_idle_rsp_b", rsp_b_o, B + 32'd10);
    @(negedge clk_i);
    // Still locked a cycle later: the lock does not time out.
    #1;
    chk("lk_hold_ready0", {31'd0, req0_ready_o}, 32'd0);
    // Requester 1 reads again under lock, then reset lands while that response is showing.
    apply(rd(5'd1, 5'd1, 1'b0), rd(5'd3, 5'd3, 1'b1));
    #1;
    chk("lk_read_ready1", {31'd0, req1_ready_o}, 32'd1);
    @(negedge clk_i);
    apply(rd(5'd1, 5'd1, 1'b0), wr(5'd6, 32'hDEAD_BEEF, 1'b1));
    #1;
    chk("pre_rst_rsp1_valid", {31'd0, rsp1_valid_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_rsp1_valid", {31'd0, rsp1_valid_o}, 32'd0);
    chk("rst_rsp_a", rsp_a_o, 32'd0);
    chk("rst_wren", {31'd0, wren_o}, 32'd0);
    @(negedge clk_i);
    // Release with both contending: lock is gone and requester 0 wins first.
    rst_i = 1'b0;
    apply(rd(5'd1, 5'd1, 1'b0), rd(5'd2, 5'd2, 1'b0));
    #1;
    chk("post_rst_ready0", {31'd0, req0_ready_o}, 32'd1);
    chk("post_rst_ready1", {31'd0, req1_ready_o}, 32'd0);
    chk("post_rst_aa", {27'd0, aa_o}, 32'd1);
    @(negedge clk_i);
    // Next cycle requester 1 gets its turn, and requester 0's response shows.
    #1;
    chk("post_rst2_ready1", {31'd0, req1_ready_o}, 32'd1);
    chk("post_rst2_rsp0_valid", {31'd0, rsp0_valid_o}, 32'd1);
    chk("post_rst2_rsp_a", rsp_a_o, B + 32'd1);
    @(negedge clk_i);
    apply(idle(), idle());
    @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter and sequencer for the 32x32 register file (two combinational read ports, one clocked write port, x0 hard-wired to zero). Sits between the register file and its two users: requester 0 (core control unit / writeback) and requester 1 (debug / test access). It grants at most one transaction per cycle, round-robin, and supports an optional lock for multi-cycle read-modify-write sequences. It returns registered read data one cycle after acceptance.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- reqN_valid_i  in  1  requester N (N=0,1) has a transaction
- reqN_ready_o  out  1  requester N's transaction is accepted this cycle (valid & ready)
- reqN_we_i  in  1  1 = write aw/wdata, 0 = read ra/rb
- reqN_ra_i, reqN_rb_i  in  ADDR_W  read indices
- reqN_rw_i  in  ADDR_W  write index
- reqN_wdata_i  in  DATA_W  write data
- reqN_lock_i  in  1  keep the grant after this transaction
- rspN_valid_o  out  1  read data for requester N is valid this cycle
- rsp_a_o, rsp_b_o  out  DATA_W  registered read data, shared by both requesters
- aa_o, ab_o, aw_o  out  ADDR_W  to register file
- wren_o  out  1  to register file
- wrdata_o  out  DATA_W  to register file
- a_i, b_i  in  DATA_W  from register file (combinational read)

## Operation
- State: last_r (index of last granted requester), lock_r (0 = none, 1 = locked), owner_r (locked requester), rsp registers.
- Grant is combinational each cycle:
  - If locked, only owner_r may be granted. The other requester's ready stays 0.
  - Else, if exactly one requester is valid, it is granted.
  - Else, if both are valid, the requester != last_r is granted.
- reqN_ready_o = grant to N. It may be 1 only while reqN_valid_i = 1. At most one ready per cycle.
- Granted read: aa_o/ab_o = ra/rb and wren_o = 0. On the clock edge, a_i/b_i are captured into rsp_a_o/rsp_b_o, and rspN_valid_o = 1 for exactly the next cycle.
- Granted write: aw_o = rw, wrdata_o = wdata, wren_o = 1, except rw = 0, where wren_o = 0. The write is still accepted and produces no response.
- No grant: all register-file outputs are 0 and wren_o = 0.
- Acceptance updates last_r to the granted index.
  - If lock_i = 1: lock_r is set to 1 and owner_r to the granted index.
  - If lock_i = 0: lock_r is cleared.
- While locked and the owner is not valid, nothing is granted. The lock is held indefinitely.
- There is no response backpressure. Requesters must take the response on the rsp_valid cycle.
- rsp_a_o/rsp_b_o hold their last captured value when no read is accepted.

## Timing
- Reset (asynchronous, immediate): rsp0/1_valid_o = 0, rsp_a_o = rsp_b_o = 0, lock_r = 0, last_r = 1 (so requester 0 wins the first contention).
- Combinational outputs follow the reset state: ready = 0 unless a request is valid and grantable.
- Read latency is 1 cycle: request accepted at edge k, data valid during cycle k+1.
- Write commits at the accepting edge. A read accepted in the following cycle returns the new value (read-after-write = 1 cycle).
- Back-to-back accepts are allowed every cycle, giving one transaction per cycle of throughput.
- Reset mid-lock or mid-response: the lock is released and a pending rsp_valid is dropped. No write is issued during reset.
- Simultaneous locked accept by the owner and a request from the other requester: the other requester waits until the owner's first accept with lock_i = 0. The cycle after that, the other requester wins if contending.

## Test plan
- Reset, then request only 0 (read ra=0, rb=2): ready0 = 1 the same cycle. Next cycle rsp0_valid = 1, rsp_a = 0, rsp_b = 0, rsp1_valid = 0.
- Req0 write x2 = 0x000000FF, then read ra=2 the next cycle: wren_o pulses for one cycle, then rsp_a = 0x000000FF one cycle later.
- Both requesters valid continuously with reads: grants alternate 0,1,0,1… and no requester is starved for more than 1 cycle.
- Req1 write x0 = 0xFFFFFFFF: ready1 = 1, wren_o = 0, and a subsequent read of x0 returns 0.
- Req1 locked sequence (read x5 lock=1, write x5 = 0x12345678 lock=0) with req0 valid throughout: ready0 = 0 for both cycles, req0 is granted in the cycle after the unlocking write, and a read of x5 returns 0x12345678.
- Assert rst_i while locked with a read in flight: rsp_valid drops immediately. After release, req0 is granted first.
